// File: rtl/gesture_event_dispatch_pkg.sv
// Shared types and helpers for the gesture event front end.
package gesture_pkg;

  typedef enum logic [1:0] {
    MODE_PULSE = 2'b00,
    MODE_HOLD  = 2'b01,
    MODE_LATCH = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  localparam int unsigned N_CH_DEFAULT = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Index of the set bit of a one-hot vector (zero-extended to 16 bits).
  function automatic int unsigned onehot_to_idx(input logic [15:0] v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/gesture_event_dispatch_if.sv
// Event read port: valid/ready handshake carrying a channel code.
interface gesture_event_dispatch_if #(
  parameter int unsigned CW = 2
);
  logic          evt_valid;
  logic [CW-1:0] evt_code;
  logic          evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/gesture_event_dispatch_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; push into a full FIFO succeeds only alongside a pop.
module gest_evt_fifo
  import gesture_pkg::*;
#(
  parameter int unsigned CW         = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [CW-1:0] din,
  input  logic          pop,
  output logic [CW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int unsigned AW = clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] mem [FIFO_DEPTH];
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/gesture_event_dispatch.sv
// Gesture event front end: one-hot edge accept with lockout, PULSE/HOLD/LATCH flags,
// and a queued channel-code read port.
module gesture_event_dispatch
  import gesture_pkg::*;
#(
  parameter int unsigned N_CH       = N_CH_DEFAULT,
  parameter int unsigned HOLD_CYC   = 50000000,
  parameter int unsigned LOCK_CYC   = 25000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [N_CH-1:0]           gest_data,
  input  logic [1:0]                mode,
  output logic [N_CH-1:0]           flag,
  gesture_event_dispatch_if.master  evt,
  output logic                      multi_err,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int unsigned CW = (clog2(N_CH) > 1) ? clog2(N_CH) : 1;
  localparam int unsigned HW = (clog2(HOLD_CYC + 1) > 1) ? clog2(HOLD_CYC + 1) : 1;
  localparam int unsigned LW = (clog2(LOCK_CYC + 1) > 1) ? clog2(LOCK_CYC + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYC);

  logic [N_CH-1:0] data_d;
  logic [N_CH-1:0] pedge;
  logic [15:0]     pedge16;
  logic [CW-1:0]   idx;
  mode_e           mode_d;
  logic [HW-1:0]   hold_cnt;
  logic [LW-1:0]   lock_cnt;
  logic            multi;
  logic            accept;
  logic            mode_chg;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic            drop;
  logic [CW-1:0]   fifo_dout;

  always_comb begin
    pedge              = gest_data & ~data_d;
    pedge16            = '0;
    pedge16[N_CH-1:0]  = pedge;
    idx                = CW'(onehot_to_idx(pedge16));
    multi              = (pedge & (pedge - N_CH'(1))) != '0;
    accept             = (pedge != '0) && !multi && (lock_cnt == '0);
    mode_chg           = (mode != mode_d);
    fifo_pop           = !fifo_empty && evt.evt_ready;
    drop               = accept && fifo_full && !fifo_pop;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_d    <= '0;
      mode_d    <= MODE_PULSE;
      flag      <= '0;
      hold_cnt  <= '0;
      lock_cnt  <= '0;
      multi_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      data_d    <= gest_data;
      mode_d    <= mode_e'(mode);
      multi_err <= multi;

      if (accept)                lock_cnt <= LOCK_LOAD;
      else if (lock_cnt != '0)   lock_cnt <= lock_cnt - LW'(1);

      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      // An accept overrides a same-cycle mode change and is applied under the new mode.
      if (accept) begin
        flag     <= N_CH'(1) << idx;
        hold_cnt <= (mode == MODE_HOLD) ? HOLD_LOAD : '0;
      end else if (mode_chg) begin
        flag     <= '0;
        hold_cnt <= '0;
      end else begin
        case (mode)
          MODE_HOLD: begin
            if (hold_cnt == '0) flag <= '0;
            else                hold_cnt <= hold_cnt - HW'(1);
          end
          MODE_LATCH: flag <= flag;
          default:    flag <= '0;
        endcase
      end
    end
  end

  gest_evt_fifo #(
    .CW         (CW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (accept),
    .din   (idx),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_code  = fifo_dout;

endmodule

// File: doc/gesture_event_dispatch.md
Name: gesture_event_dispatch

Overview:
Parametrised gesture-event front end that sits between paj7620_top (per-gesture level bits) and the output consumers (beep, seg_dynamic, vending FSM).
- Detects rising edges on N_CH gesture lines and accepts only clean one-hot events.
- Applies a re-trigger lockout.
- Drives a flag vector in PULSE, HOLD or LATCH mode.
- Queues accepted events as channel codes in a small FIFO with a valid/ready read port.

Parameters:
N_CH, 4, number of gesture lines; 2..16.
HOLD_CYC, 50000000, flag high time in HOLD mode, in clocks; at least 1.
LOCK_CYC, 25000000, post-accept lockout, in clocks; 0 disables lockout.
FIFO_DEPTH, 4, event queue entries; power of 2, at least 2.
CW (derived), max(1, clog2(N_CH)), event code width.

Ports:
sys_clk    in   1      system clock
sys_rst_n  in   1      asynchronous active-low reset
gest_data  in   N_CH   gesture level bits, already in the sys_clk domain
mode       in   2      00 PULSE, 01 HOLD, 10 LATCH, 11 treated as PULSE
flag       out  N_CH   registered one-hot or zero gesture flag
evt_valid  out  1      FIFO not empty
evt_code   out  CW     channel index at FIFO head
evt_ready  in   1      consumer pops the head on evt_valid && evt_ready
multi_err  out  1      one-cycle pulse when an edge vector has more than one bit set
overflow   out  1      sticky; set on a dropped event
ovf_clr    in   1      clears overflow

Behaviour:
- Reset values: all registers 0, including data_d, flag, counters, FIFO pointers, overflow and multi_err. evt_valid = 0 during and after reset.
- Edge detect: data_d <= gest_data on every clock. pedge = gest_data & ~data_d, computed combinationally.
- Accept condition: pedge is exactly one-hot and lock_cnt == 0.
  - Accepted channel index i = position of the set bit.
  - lock_cnt <= LOCK_CYC, then decrements by 1 per clock down to 0.
- pedge with 2 or more bits set: multi_err = 1 on the next cycle. No accept, no lockout load, flag unchanged.
- pedge zero, or an edge while locked out: ignored silently. No error, lock_cnt is not reloaded.
- Latency: gest_data bit rises before edge k, so the edge is sampled at k. flag and FIFO push are visible after edge k, i.e. one clock.
- flag, mode PULSE: flag = 1<<i for exactly one cycle, then 0.
- flag, mode HOLD:
  - Accept loads flag = 1<<i and hold_cnt = HOLD_CYC - 1.
  - flag clears when hold_cnt reaches 0; flag is high for exactly HOLD_CYC cycles.
  - A new accept during hold replaces flag and restarts hold_cnt.
- flag, mode LATCH: flag = 1<<i until the next accept replaces it. It never clears by itself.
- Mode change: mode_d registers mode. If mode != mode_d, flag and hold_cnt clear on that edge. An accept on the same edge wins and is applied using the new mode.
- FIFO:
  - Push code i on accept.
  - evt_code shows the head combinationally from registered pointers.
  - Pop when evt_valid && evt_ready; evt_ready with the FIFO empty is ignored.
  - Full, push and pop on the same cycle: both occur, count unchanged, no overflow.
  - Full, push and no pop: new event dropped, overflow <= 1. flag still updates normally.
  - Pointers are (log2 FIFO_DEPTH)+1 bits with wrap-bit full/empty detection.
- overflow: ovf_clr clears it. If ovf_clr and a drop happen on the same cycle, set wins.
- Reset mid-operation: all state clears immediately (asynchronous). The FIFO is flushed. data_d = 0, so any line already high at release produces an edge on the first clock after reset release.
- Counter widths: clog2(HOLD_CYC+1) and clog2(LOCK_CYC+1), minimum 1 bit. No arithmetic wrap is allowed.

Decomposition:
- Package gesture_pkg: mode encodings (MODE_PULSE, MODE_HOLD, MODE_LATCH), default N_CH, a clog2 helper function, and a onehot-to-index function.
- Sub-module gest_evt_fifo: a synchronous FIFO parametrised by width CW and FIFO_DEPTH. Ports: push, din, pop, dout, empty, full.
- Edge detect, lockout and flag logic stay in the top module.

Test Plan:
- Bench parameters: N_CH=4, HOLD_CYC=5, LOCK_CYC=3, FIFO_DEPTH=4.
- PULSE: gest_data 0000->0100 -> flag=0100 for 1 cycle, one clock after sampling; evt_valid=1 and evt_code=2 until popped.
- HOLD: 0001 edge -> flag=0001 for exactly 5 cycles. A 0010 edge 4 cycles later -> flag=0010, hold restarts and lasts 5 more cycles.
- Lockout: 0001 edge, then 1000 edge 2 cycles later -> second edge ignored, flag unchanged, FIFO holds one entry. Same 1000 edge 4 cycles after the first -> accepted.
- Multi-edge: 0000->0110 -> multi_err pulse of 1 cycle, flag unchanged, no push, lock_cnt stays 0.
- FIFO: 5 accepted events with evt_ready=0 -> 4 queued, overflow=1. Then 4 pops yield codes in arrival order. ovf_clr -> overflow=0. Full plus simultaneous push and pop -> no overflow.
- LATCH and reset: LATCH mode, 0100 edge -> flag stays 0100 indefinitely. Switch to PULSE -> flag=0 next cycle. Reset asserted mid-hold -> flag=0, evt_valid=0 immediately.
